// File: rtl/serial_add_sched.sv
// serial_add_sched
// Two-requester round-robin scheduler wrapped around a bit-serial adder.
// A granted operand pair is captured in IDLE, added LSB-first over exactly
// WIDTH SHIFT cycles, and the result is held in DONE until the consumer
// takes it.
//
// Ports:
//   clk_i, resetn_i          clock, asynchronous active-low reset
//   reqN_valid_i/ready_o     requester N handshake (N = 0, 1)
//   reqN_a_i, reqN_b_i       requester N operands
//   res_valid_o/res_ready_i  result handshake
//   res_sum_o, res_cout_o    a + b mod 2^WIDTH and carry-out
//   res_id_o                 requester that issued the job
//   busy_o                   high whenever the sequencer is not IDLE
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_cout_o,
  output logic             res_id_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             id_r;
  logic             last_id_r;
  logic [CW-1:0]    cnt_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             accept_s;
  logic             sum_bit_s;
  logic             carry_nxt_s;

  // Full-adder carry: majority of the three input bits.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Round-robin grant, only in IDLE; on a tie the requester not served last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        if (last_id_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (req0_valid_i) begin
        gnt0_s = 1'b1;
      end else if (req1_valid_i) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // A grant is only ever issued to a valid requester, so grant means accept.
  assign accept_s     = gnt0_s | gnt1_s;
  assign req0_ready_o = gnt0_s;
  assign req1_ready_o = gnt1_s;

  // One bit of the serial add per SHIFT cycle.
  assign sum_bit_s   = a_r[0] ^ b_r[0] ^ carry_r;
  assign carry_nxt_s = maj3(a_r[0], b_r[0], carry_r);

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, serial shift datapath and job bookkeeping.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      carry_r   <= 1'b0;
      id_r      <= 1'b0;
      last_id_r <= 1'b1;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r       <= gnt1_s ? req1_a_i : req0_a_i;
            b_r       <= gnt1_s ? req1_b_i : req0_b_i;
            sum_r     <= '0;
            carry_r   <= 1'b0;
            id_r      <= gnt1_s;
            last_id_r <= gnt1_s;
            cnt_r     <= '0;
          end
        end
        ST_SHIFT: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          // LSB-first result enters at the MSB and walks down to bit 0.
          sum_r   <= {sum_bit_s, sum_r[WIDTH-1:1]};
          carry_r <= carry_nxt_s;
          cnt_r   <= cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign res_valid_o = (state_r == ST_DONE);
  assign busy_o      = (state_r != ST_IDLE);
  assign res_sum_o   = sum_r;
  assign res_cout_o  = carry_r;
  assign res_id_o    = id_r;

endmodule

// File: tb/tb_serial_add_sched.sv
module tb_serial_add_sched;

  localparam int WIDTH = 8;

  logic             clk_i;
  logic             resetn_i;
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [WIDTH-1:0] req0_a_i;
  logic [WIDTH-1:0] req0_b_i;
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [WIDTH-1:0] req1_a_i;
  logic [WIDTH-1:0] req1_b_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_sum_o;
  logic             res_cout_o;
  logic             res_id_o;
  logic             busy_o;

  int total;
  int bad;

  serial_add_sched #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_sum_o    (res_sum_o),
    .res_cout_o   (res_cout_o),
    .res_id_o     (res_id_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; raises valid, checks grant, ends at acceptance edge +1.
  task automatic start_job(input logic id, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b;
    end else begin
      req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b;
    end
    #1;
    chk("grant_ready", {30'd0, req1_ready_o, req0_ready_o}, id ? 32'd2 : 32'd1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
  endtask

  // Waits for the result, checks it and latency, then completes the handshake.
  task automatic finish_job(input int exp_lat, input logic exp_id,
                            input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    lat = 0;
    while (!res_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat = lat + 1;
    end
    chk("latency", lat, exp_lat);
    chk("res_valid", {31'd0, res_valid_o}, 32'd1);
    chk("res_sum", {24'd0, res_sum_o}, {24'd0, exp_sum});
    chk("res_cout", {31'd0, res_cout_o}, {31'd0, exp_cout});
    chk("res_id", {31'd0, res_id_o}, {31'd0, exp_id});
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk("idle_after_take", {30'd0, busy_o, res_valid_o}, 32'd0);
  endtask

  task automatic do_reset();
    resetn_i = 1'b0;
    #3;
    chk("reset_outputs",
        {19'd0, res_valid_o, res_sum_o, res_cout_o, res_id_o, busy_o, req0_ready_o, req1_ready_o},
        32'd0);
    @(posedge clk_i); #1;
    resetn_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    int n0;
    int n1;
    int njobs;
    int cyc;
    logic acc0;
    logic acc1;
    logic both_ready;
    logic hold_ok;
    logic [7:0] held_sum;
    logic exp_id;

    total = 0;
    bad = 0;
    resetn_i = 1'b1;
    req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0;
    req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0;
    res_ready_i = 1'b0;

    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'h12, 8'h34, 8'h46, 1'b0};

    #2;
    do_reset();
    chk("idle_no_valid", {30'd0, busy_o, req0_ready_o}, 32'd0);

    // Round robin: both requesters valid until each has had 3 jobs accepted.
    req0_valid_i = 1'b1; req0_a_i = 8'h10; req0_b_i = 8'h20;
    req1_valid_i = 1'b1; req1_a_i = 8'hF0; req1_b_i = 8'h20;
    res_ready_i = 1'b1;
    n0 = 0; n1 = 0; njobs = 0; cyc = 0;
    both_ready = 1'b0;
    exp_id = 1'b0;
    #1;
    while (njobs < 6 && cyc < 200) begin
      acc0 = req0_valid_i & req0_ready_o;
      acc1 = req1_valid_i & req1_ready_o;
      if (req0_ready_o && req1_ready_o) both_ready = 1'b1;
      if (res_valid_o) begin
        chk("rr_id", {31'd0, res_id_o}, {31'd0, exp_id});
        chk("rr_sum", {23'd0, res_cout_o, res_sum_o}, exp_id ? 32'h110 : 32'h030);
        exp_id = ~exp_id;
        njobs = njobs + 1;
      end
      @(posedge clk_i); #1;
      cyc = cyc + 1;
      if (acc0) begin
        n0 = n0 + 1;
        if (n0 == 3) req0_valid_i = 1'b0;
      end
      if (acc1) begin
        n1 = n1 + 1;
        if (n1 == 3) req1_valid_i = 1'b0;
      end
    end
    chk("rr_jobs", njobs, 6);
    chk("rr_never_both_ready", {31'd0, both_ready}, 32'd0);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    res_ready_i = 1'b0;
    @(posedge clk_i); #1;

    // Table-driven single jobs.
    for (int i = 0; i < 6; i++) begin
      start_job(vecs[i].id, vecs[i].a, vecs[i].b);
      finish_job(WIDTH, vecs[i].id, vecs[i].sum, vecs[i].cout);
    end

    // Back-pressure: hold DONE for 20 cycles with req1 waiting.
    start_job(1'b0, 8'h5A, 8'h3C);
    req1_valid_i = 1'b1; req1_a_i = 8'h01; req1_b_i = 8'h02;
    cyc = 0;
    while (!res_valid_o && cyc < 40) begin
      @(posedge clk_i); #1;
      cyc = cyc + 1;
    end
    held_sum = res_sum_o;
    chk("bp_sum", {24'd0, held_sum}, 32'h96);
    hold_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      if (!res_valid_o || res_sum_o !== 8'h96 || res_cout_o !== 1'b0 ||
          res_id_o !== 1'b0 || req0_ready_o || req1_ready_o)
        hold_ok = 1'b0;
    end
    chk("bp_hold_stable", {31'd0, hold_ok}, 32'd1);
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk("bp_release_idle", {29'd0, busy_o, res_valid_o, req1_ready_o}, 32'd1);
    req1_valid_i = 1'b0;
    start_job(1'b1, 8'h01, 8'h02);
    finish_job(WIDTH, 1'b1, 8'h03, 1'b0);

    // Reset at shift count 4 aborts the job.
    start_job(1'b0, 8'hAA, 8'h55);
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    resetn_i = 1'b0;
    #1;
    chk("midreset_outputs",
        {19'd0, res_valid_o, res_sum_o, res_cout_o, res_id_o, busy_o, req0_ready_o, req1_ready_o},
        32'd0);
    @(posedge clk_i); #1;
    resetn_i = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i); #1;
      if (res_valid_o || busy_o) hold_ok = 1'b0;
    end
    chk("midreset_no_result", {31'd0, hold_ok}, 32'd1);
    start_job(1'b0, 8'hAA, 8'h56);
    finish_job(WIDTH, 1'b0, 8'h00, 1'b1);

    // Valid raised and dropped while busy is ignored; only req1 is served.
    start_job(1'b1, 8'h01, 8'h02);
    req0_valid_i = 1'b1; req0_a_i = 8'h77; req0_b_i = 8'h11;
    hold_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      if (req0_ready_o) hold_ok = 1'b0;
    end
    req0_valid_i = 1'b0;
    chk("busy_no_ready", {31'd0, hold_ok}, 32'd1);
    finish_job(WIDTH - 3, 1'b1, 8'h03, 1'b0);
    start_job(1'b1, 8'h40, 8'h02);
    finish_job(WIDTH, 1'b1, 8'h42, 1'b0);
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      if (busy_o) hold_ok = 1'b0;
    end
    chk("dropped_req_not_served", {31'd0, hold_ok}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Two-requester scheduler and sequencer for the shared bit-serial adder datapath. It arbitrates between two operand sources with round-robin priority and captures the granted operand pair into internal shift registers. It then runs the LOAD→SHIFT serial-add sequence for exactly WIDTH cycles and returns the sum, carry-out and requester ID over a valid/ready result port. It sits between the operand producers and result consumers, owning the serial adder so no requester drives it directly.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range ≥ 2
- clk_i  input  1  single clock, all logic on rising edge
- resetn_i  input  1  asynchronous, active-low reset
- req0_valid_i  input  1  requester 0 has an operand pair
- req0_ready_o  output  1  requester 0 pair accepted this cycle when high with valid
- req0_a_i, req0_b_i  input  WIDTH  requester 0 operands
- req1_valid_i  input  1  requester 1 has an operand pair
- req1_ready_o  output  1  requester 1 pair accepted this cycle when high with valid
- req1_a_i, req1_b_i  input  WIDTH  requester 1 operands
- res_valid_o  output  1  result available
- res_ready_i  input  1  consumer takes result
- res_sum_o  output  WIDTH  a + b mod 2^WIDTH
- res_cout_o  output  1  carry-out of the addition
- res_id_o  output  1  requester that issued the job
- busy_o  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free; any unused encoding returns to IDLE.
- Arbitration happens in IDLE only:
  - Grant is combinational from the valids and a last-served pointer `last_id`. `last_id` resets to 1, so requester 0 wins the first tie.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester ≠ `last_id` is granted.
  - `reqN_ready_o` is high only in IDLE and only for the granted requester. It is never high for both requesters.
- Acceptance on edge where reqN_valid_i && reqN_ready_o:
  - Capture a and b into shift registers.
  - Clear carry flop; clear sum register.
  - Set id = N and `last_id` = N.
  - Set count = 0 and go to SHIFT.
- SHIFT, each edge:
  - sum bit = a[0]^b[0]^c; new c = majority(a[0],b[0],c).
  - Shift a and b right; shift the sum bit into sum MSB (sum shifts right).
  - Increment count.
  - On the edge where count == WIDTH-1, go to DONE. Exactly WIDTH shift edges occur.
- DONE:
  - res_valid_o = 1. res_sum_o holds the sum register, res_cout_o holds the carry flop, res_id_o holds the captured id.
  - Outputs stay stable while res_valid_o && !res_ready_i.
  - On res_valid_o && res_ready_i, go to IDLE.
- Requester inputs are ignored outside the acceptance edge. Dropping valid before grant is legal and has no effect.
- Arithmetic: the sum is modulo 2^WIDTH and the carry is the (WIDTH+1)-th bit. No carry-in.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, count = 0, `last_id` = 1.
  - Shift, sum and carry registers cleared.
  - res_valid_o = 0, res_sum_o = 0, res_cout_o = 0, res_id_o = 0, busy_o = 0.
  - req0_ready_o and req1_ready_o follow the IDLE grant logic as soon as reset deasserts.
- Latency: for an acceptance at edge E0, res_valid_o is high from the cycle after edge E0+WIDTH.
- Minimum job spacing is WIDTH+2 cycles: accept edge, WIDTH shift edges, then the result handshake edge returning to IDLE. The next acceptance is possible at the earliest on the first IDLE cycle.
- No acceptance is possible in SHIFT or DONE. ready stays low there even when valid is high.
- Result back-pressure holds DONE indefinitely. Waiting requesters stall with no loss.
- Reset mid-SHIFT or in DONE aborts the job: no result is produced, and an unaccepted result is lost.
- Simultaneous valids in the same IDLE cycle: exactly one grant per the round-robin rule. The loser keeps valid high and is granted in the next IDLE period.

## Test plan
- WIDTH=8, req0 a=0x5A, b=0x3C -> res_sum_o=0x96, res_cout_o=0, res_id_o=0; res_valid_o rises 8 edges after acceptance.
- req1 a=0xFF, b=0x01 -> sum=0x00, cout=1, id=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Both valid continuously with 3 jobs each -> grants alternate 0,1,0,1,0,1 starting with 0 after reset. ready is never high for both requesters.
- Hold res_ready_i=0 for 20 cycles in DONE -> res_valid_o stays high, sum/cout/id unchanged, both ready low. On release, return to IDLE next edge.
- Assert resetn_i low at shift count 4 -> all outputs 0 immediately, no res_valid_o. A new job after release produces the correct sum.
- Raise req0_valid_i, drop it before grant while busy, then issue req1 -> only req1 is served, result id=1.
